// File: rtl/sram_wr_sel.sv
// Write-side bank selector: streams a valid/ready word sequence into the weight banks,
// then the data banks, bank-major, with a one-cycle registered write path.
//
// state  | meaning
// IDLE   | waiting for start; no words accepted, outputs idle
// LOAD_W | filling weight banks w0..w(N-1), addr 0..DEPTH-1 each
// LOAD_D | filling data banks d0..d(N-1), addr 0..DEPTH-1 each
module sram_wr_sel #(
  parameter int NUM_BANKS = 8,
  parameter int DEPTH     = 99,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int IDLE_ADDR = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_BANKS-1:0] sram_wen_w,
  output logic [NUM_BANKS-1:0] sram_wen_d,
  output logic [ADDR_W-1:0]    sram_waddr,
  output logic [DATA_W-1:0]    sram_wdata,
  output logic                 busy,
  output logic                 done
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDLE_A    = ADDR_W'(IDLE_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_D = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BANK_W-1:0]    bank;
  logic [ADDR_W-1:0]    addr;
  logic                 accept;
  logic                 last_word;
  logic [NUM_BANKS-1:0] bank_onehot;

  assign in_ready    = (state != IDLE);
  assign busy        = (state != IDLE);
  assign accept      = in_valid & in_ready;
  assign last_word   = (bank == LAST_BANK) && (addr == LAST_ADDR);
  assign bank_onehot = NUM_BANKS'(1) << bank;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // done is still high in the cycle after the final accept, which masks a start
  // arriving exactly then.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !done)       state_nxt = LOAD_W;
      LOAD_W:  if (accept && last_word)  state_nxt = LOAD_D;
      LOAD_D:  if (accept && last_word)  state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
      addr <= '0;
    end else if (accept) begin
      if (addr == LAST_ADDR) begin
        addr <= '0;
        bank <= (bank == LAST_BANK) ? '0 : bank + BANK_W'(1);
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_wen_w <= '0;
      sram_wen_d <= '0;
      sram_waddr <= IDLE_A;
      sram_wdata <= '0;
      done       <= 1'b0;
    end else begin
      done <= accept && (state == LOAD_D) && last_word;
      if (accept) begin
        sram_wen_w <= (state == LOAD_W) ? bank_onehot : '0;
        sram_wen_d <= (state == LOAD_D) ? bank_onehot : '0;
        sram_waddr <= addr;
        sram_wdata <= in_data;
      end else begin
        sram_wen_w <= '0;
        sram_wen_d <= '0;
        sram_waddr <= IDLE_A;
      end
    end
  end

endmodule

// File: tb/tb_sram_wr_sel.sv
// Bench for sram_wr_sel: directed scenarios plus randomized loads, checked every cycle
// against a word-index model (index -> group/bank/addr by division).
module tb_sram_wr_sel;

  localparam int NB    = 8;
  localparam int DP    = 99;
  localparam int PER_G = NB * DP;
  localparam int TOTAL = 2 * PER_G;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [7:0]  sram_wen_w, sram_wen_d;
  logic [9:0]  sram_waddr;
  logic [63:0] sram_wdata;
  logic        busy, done;

  sram_wr_sel dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sram_wen_w(sram_wen_w), .sram_wen_d(sram_wen_d),
    .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // reference model state
  bit          m_known = 0;
  bit          m_load  = 0;
  int          m_k     = 0;
  logic [7:0]  e_wen_w = '0;
  logic [7:0]  e_wen_d = '0;
  logic [9:0]  e_waddr = 10'd127;
  logic [63:0] e_wdata = '0;
  bit          e_done  = 0;

  // Drive one cycle of inputs, predict the registered outputs, then compare.
  task automatic step(input bit r, input bit s, input bit v, input logic [63:0] d);
    bit load_before, prev_done, acc;
    int g, b, a;
    rst = r; start = s; in_valid = v; in_data = d;
    #1;
    if (m_known) chk("in_ready", {63'd0, in_ready}, {63'd0, m_load});
    load_before = m_load;
    prev_done   = e_done;
    if (r) begin
      m_load = 0; m_k = 0;
      e_wen_w = '0; e_wen_d = '0; e_waddr = 10'd127; e_wdata = '0; e_done = 0;
    end else begin
      acc = v && load_before;
      e_done = 0;
      if (acc) begin
        g = m_k / PER_G;
        b = (m_k % PER_G) / DP;
        a = m_k % DP;
        e_wen_w = (g == 0) ? 8'(1 << b) : 8'h00;
        e_wen_d = (g == 1) ? 8'(1 << b) : 8'h00;
        e_waddr = 10'(a);
        e_wdata = d;
        m_k++;
        if (m_k == TOTAL) begin
          e_done = 1; m_load = 0; m_k = 0;
        end
      end else begin
        e_wen_w = '0; e_wen_d = '0; e_waddr = 10'd127;
      end
      if (s && !load_before && !prev_done) begin
        m_load = 1; m_k = 0;
      end
    end
    @(posedge clk);
    #1;
    m_known = 1;
    chk("wen_w", {56'd0, sram_wen_w}, {56'd0, e_wen_w});
    chk("wen_d", {56'd0, sram_wen_d}, {56'd0, e_wen_d});
    chk("waddr", {54'd0, sram_waddr}, {54'd0, e_waddr});
    chk("wdata", sram_wdata, e_wdata);
    chk("done", {63'd0, done}, {63'd0, e_done});
    chk("busy", {63'd0, busy}, {63'd0, m_load});
  endtask

  initial begin
    int cyc;
    @(posedge clk); #1;

    // reset for two cycles
    step(1, 0, 0, '0);
    step(1, 1, 1, 64'hdead);
    chk("rst_wen_w", {56'd0, sram_wen_w}, 64'd0);
    chk("rst_wen_d", {56'd0, sram_wen_d}, 64'd0);
    chk("rst_waddr", {54'd0, sram_waddr}, 64'd127);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);

    // valid in idle without start: nothing accepted
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 64'(i + 500));
      chk("idle_wen", {48'd0, sram_wen_w, sram_wen_d}, 64'd0);
    end

    // full load, valid held high, data = index
    step(0, 1, 0, '0);
    for (int i = 0; i < TOTAL; i++) begin
      step(0, 0, 1, 64'(i));
      if (i == 0) begin
        chk("w0_wen_w", {56'd0, sram_wen_w}, 64'h01);
        chk("w0_waddr", {54'd0, sram_waddr}, 64'd0);
      end
      if (i == 99) begin
        chk("w99_wen_w", {56'd0, sram_wen_w}, 64'h02);
        chk("w99_waddr", {54'd0, sram_waddr}, 64'd0);
      end
      if (i == 792) begin
        chk("w792_wen_d", {56'd0, sram_wen_d}, 64'h01);
        chk("w792_wen_w", {56'd0, sram_wen_w}, 64'h00);
        chk("w792_waddr", {54'd0, sram_waddr}, 64'd0);
      end
      if (i == TOTAL - 1) begin
        chk("last_wen_d", {56'd0, sram_wen_d}, 64'h80);
        chk("last_waddr", {54'd0, sram_waddr}, 64'd98);
        chk("last_done", {63'd0, done}, 64'd1);
        chk("last_busy", {63'd0, busy}, 64'd0);
        chk("last_in_ready", {63'd0, in_ready}, 64'd0);
      end
    end
    // start in the done cycle would be ignored; here just idle a cycle
    step(0, 0, 1, 64'hbeef);

    // backpressure 1,0,0,1
    step(0, 1, 0, '0);
    step(0, 0, 1, 64'h100);
    chk("bp_addr0", {54'd0, sram_waddr}, 64'd0);
    step(0, 0, 0, 64'h101);
    chk("bp_gap_addr", {54'd0, sram_waddr}, 64'd127);
    step(0, 0, 0, 64'h102);
    chk("bp_gap_wen", {56'd0, sram_wen_w}, 64'd0);
    step(0, 0, 1, 64'h103);
    chk("bp_addr1", {54'd0, sram_waddr}, 64'd1);
    chk("bp_data1", sram_wdata, 64'h103);

    // words 2..49, then start pulsed alongside word 50
    for (int i = 2; i < 50; i++) step(0, 0, 1, 64'(i));
    step(0, 1, 1, 64'd50);
    step(0, 0, 1, 64'd51);
    chk("st_busy_addr51", {54'd0, sram_waddr}, 64'd51);
    chk("st_busy_busy", {63'd0, busy}, 64'd1);

    // continue through word 400, then reset mid-load
    for (int i = 52; i <= 400; i++) step(0, 0, 1, 64'(i));
    step(1, 0, 1, 64'd401);
    chk("abort_wen", {48'd0, sram_wen_w, sram_wen_d}, 64'd0);
    chk("abort_waddr", {54'd0, sram_waddr}, 64'd127);
    chk("abort_wdata", sram_wdata, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    step(0, 1, 0, '0);
    step(0, 0, 1, 64'h777);
    chk("restart_wen_w", {56'd0, sram_wen_w}, 64'h01);
    chk("restart_waddr", {54'd0, sram_waddr}, 64'd0);
    step(1, 0, 0, '0);

    // randomized loads: random valid gaps, data and spurious start pulses
    for (int n = 0; n < 2; n++) begin
      step(0, 1, ($urandom_range(0, 1) == 1), {$urandom, $urandom});
      cyc = 0;
      while (m_load && cyc < 4000) begin
        step(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
             {$urandom, $urandom});
        cyc++;
      end
      chk("rand_load_end", {63'd0, busy}, 64'd0);
      for (int i = 0; i < 3; i++)
        step(0, ($urandom_range(0, 1) == 1) && (i > 0), 1, {$urandom, $urandom});
      step(1, 0, 0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
